// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline controller: FSM state encoding,
// default stall timeout and interrupt vector. Optional IRQ support: PIPE_CTRL_IRQ_EN.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_TRAP     = 2'd2,
    ST_STALL    = 2'd3
  } state_e;

  localparam int unsigned DEF_MAX_STALL_CYCLES = 255;
  localparam logic [31:0] DEF_IRQ_VECTOR       = 32'h0000_0100;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_cnt.sv
// Saturating consecutive-stall counter with a sticky timeout flag.
// Expects MAX_STALL_CYCLES >= 1.
module pipe_ctrl_stall_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_STALL_CYCLES = DEF_MAX_STALL_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic busy_i,
  output logic stall_err_o
);

  localparam int unsigned CW = cnt_width(MAX_STALL_CYCLES);
  localparam logic [CW-1:0] MAX_V = CW'(MAX_STALL_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  always_comb begin
    cnt_d = '0;
    if (busy_i) begin
      cnt_d = (cnt_q == MAX_V) ? cnt_q : cnt_q + 1'b1;
    end
    // Error latches on the same edge that records the MAX-th stalled cycle.
    err_d = err_q | (busy_i && (cnt_d == MAX_V));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign stall_err_o = err_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: holds, flushes and PC redirects.
// Optional interrupt entry (irq/ack/epc ports, TRAP state) under PIPE_CTRL_IRQ_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_STALL_CYCLES = DEF_MAX_STALL_CYCLES,
  parameter logic [31:0] IRQ_VECTOR       = DEF_IRQ_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_jump_req_i,
  input  logic [31:0] ctrl_jump_addr_i,
  input  logic        ctrl_ld_use_stall_i,
  input  logic        ctrl_ex_busy_i,
  input  logic        ctrl_mem_busy_i,
  input  logic [31:0] ctrl_ex_pc_i,
  output logic        ctrl_pc_jump_en_o,
  output logic [31:0] ctrl_pc_jump_addr_o,
  output logic        ctrl_pc_hold_o,
  output logic        ctrl_if_id_hold_o,
  output logic        ctrl_id_ex_hold_o,
  output logic        ctrl_ex_mem_hold_o,
  output logic        ctrl_if_id_flush_o,
  output logic        ctrl_id_ex_flush_o,
  output logic        ctrl_ex_mem_flush_o,
  output logic        ctrl_mem_wb_flush_o,
  output logic        ctrl_stall_err_o,
`ifdef PIPE_CTRL_IRQ_EN
  input  logic        ctrl_irq_i,
  output logic        ctrl_irq_ack_o,
  output logic [31:0] ctrl_epc_o,
`endif
  output logic [1:0]  ctrl_state_o
);

  state_e state_q, state_d;
  logic   busy_any;

`ifdef PIPE_CTRL_IRQ_EN
  logic [31:0] epc_q, epc_d;
  logic        irq_take;
`else
  logic        unused_irq_inputs;
  assign unused_irq_inputs = ^{ctrl_ex_pc_i, IRQ_VECTOR};
`endif

  assign busy_any = ctrl_ex_busy_i | ctrl_mem_busy_i;

  always_comb begin
    state_d             = state_q;
    ctrl_pc_jump_en_o   = 1'b0;
    ctrl_pc_jump_addr_o = 32'h0;
    ctrl_pc_hold_o      = 1'b0;
    ctrl_if_id_hold_o   = 1'b0;
    ctrl_id_ex_hold_o   = 1'b0;
    ctrl_ex_mem_hold_o  = 1'b0;
    ctrl_if_id_flush_o  = 1'b0;
    ctrl_id_ex_flush_o  = 1'b0;
    ctrl_ex_mem_flush_o = 1'b0;
    ctrl_mem_wb_flush_o = 1'b0;
`ifdef PIPE_CTRL_IRQ_EN
    epc_d          = epc_q;
    ctrl_irq_ack_o = 1'b0;
    irq_take       = ctrl_irq_i && !busy_any &&
                     ((state_q == ST_RUN) || (state_q == ST_STALL));
`endif

    if (state_q == ST_TRAP) begin
      ctrl_if_id_flush_o = 1'b1;
`ifdef PIPE_CTRL_IRQ_EN
      ctrl_irq_ack_o     = 1'b1;
`endif
      state_d            = ST_RUN;
    end else begin
      // REDIRECT squashes the fetch already issued down the old path.
      if (state_q == ST_REDIRECT) ctrl_if_id_flush_o = 1'b1;
      state_d = ST_RUN;
`ifdef PIPE_CTRL_IRQ_EN
      if (irq_take) begin
        ctrl_pc_jump_en_o   = 1'b1;
        ctrl_pc_jump_addr_o = IRQ_VECTOR;
        ctrl_if_id_flush_o  = 1'b1;
        ctrl_id_ex_flush_o  = 1'b1;
        ctrl_ex_mem_flush_o = 1'b1;
        epc_d               = ctrl_ex_pc_i;
        state_d             = ST_TRAP;
      end else
`endif
      if (ctrl_mem_busy_i) begin
        ctrl_pc_hold_o      = 1'b1;
        ctrl_if_id_hold_o   = 1'b1;
        ctrl_id_ex_hold_o   = 1'b1;
        ctrl_ex_mem_hold_o  = 1'b1;
        ctrl_mem_wb_flush_o = 1'b1;
        state_d             = ST_STALL;
      end else if (ctrl_ex_busy_i) begin
        ctrl_pc_hold_o      = 1'b1;
        ctrl_if_id_hold_o   = 1'b1;
        ctrl_id_ex_hold_o   = 1'b1;
        ctrl_ex_mem_flush_o = 1'b1;
        state_d             = ST_STALL;
      end else if (ctrl_jump_req_i) begin
        ctrl_pc_jump_en_o   = 1'b1;
        ctrl_pc_jump_addr_o = ctrl_jump_addr_i;
        ctrl_if_id_flush_o  = 1'b1;
        ctrl_id_ex_flush_o  = 1'b1;
        state_d             = ST_REDIRECT;
      end else if (ctrl_ld_use_stall_i) begin
        ctrl_pc_hold_o      = 1'b1;
        ctrl_if_id_hold_o   = 1'b1;
        ctrl_id_ex_flush_o  = 1'b1;
      end
    end

    if (ctrl_if_id_flush_o) ctrl_if_id_hold_o = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
`ifdef PIPE_CTRL_IRQ_EN
      epc_q   <= 32'h0;
`endif
    end else begin
      state_q <= state_d;
`ifdef PIPE_CTRL_IRQ_EN
      epc_q   <= epc_d;
`endif
    end
  end

`ifdef PIPE_CTRL_IRQ_EN
  assign ctrl_epc_o = epc_q;
`endif
  assign ctrl_state_o = state_q;

  pipe_ctrl_stall_cnt #(
    .MAX_STALL_CYCLES(MAX_STALL_CYCLES)
  ) u_stall_cnt (
    .clk        (clk),
    .rst        (rst),
    .busy_i     (busy_any),
    .stall_err_o(ctrl_stall_err_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl (MAX_STALL_CYCLES=4); IRQ vectors
// are included when PIPE_CTRL_IRQ_EN is defined.
module tb_pipe_ctrl;

  localparam int W = 77;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_req = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        ld_use = 1'b0;
  logic        ex_busy = 1'b0;
  logic        mem_busy = 1'b0;
  logic [31:0] ex_pc = 32'h0;
  logic        irq = 1'b0;

  logic        jen;
  logic [31:0] jaddr;
  logic        pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic        stall_err;
  logic [1:0]  state;
  logic        irq_ack_w;
  logic [31:0] epc_w;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           tests_run = 0;
  int           tests_failed = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.MAX_STALL_CYCLES(4), .IRQ_VECTOR(32'h0000_0100)) dut (
    .clk                (clk),
    .rst                (rst),
    .ctrl_jump_req_i    (jump_req),
    .ctrl_jump_addr_i   (jump_addr),
    .ctrl_ld_use_stall_i(ld_use),
    .ctrl_ex_busy_i     (ex_busy),
    .ctrl_mem_busy_i    (mem_busy),
    .ctrl_ex_pc_i       (ex_pc),
    .ctrl_pc_jump_en_o  (jen),
    .ctrl_pc_jump_addr_o(jaddr),
    .ctrl_pc_hold_o     (pc_hold),
    .ctrl_if_id_hold_o  (if_id_hold),
    .ctrl_id_ex_hold_o  (id_ex_hold),
    .ctrl_ex_mem_hold_o (ex_mem_hold),
    .ctrl_if_id_flush_o (if_id_flush),
    .ctrl_id_ex_flush_o (id_ex_flush),
    .ctrl_ex_mem_flush_o(ex_mem_flush),
    .ctrl_mem_wb_flush_o(mem_wb_flush),
    .ctrl_stall_err_o   (stall_err),
`ifdef PIPE_CTRL_IRQ_EN
    .ctrl_irq_i         (irq),
    .ctrl_irq_ack_o     (irq_ack_w),
    .ctrl_epc_o         (epc_w),
`endif
    .ctrl_state_o       (state)
  );

`ifndef PIPE_CTRL_IRQ_EN
  assign irq_ack_w = 1'b0;
  assign epc_w     = 32'h0;
`endif

  // Layout: {ack, epc, state, jump_en, jump_addr, holds[pc,if_id,id_ex,ex_mem],
  //          flushes[if_id,id_ex,ex_mem,mem_wb], stall_err}
  function automatic logic [W-1:0] ex(input logic [1:0] st, input logic je,
                                      input logic [31:0] ja, input logic [3:0] h,
                                      input logic [3:0] f, input logic err,
                                      input logic ack, input logic [31:0] epc);
    return {ack, epc, st, je, ja, h, f, err};
  endfunction

  task automatic vec(input string nm, input logic jr, input logic [31:0] ja,
                     input logic lu, input logic eb, input logic mb,
                     input logic ir, input logic [31:0] pc, input logic [W-1:0] e);
    @(posedge clk);
    #1;
    rst = 1'b0; jump_req = jr; jump_addr = ja; ld_use = lu;
    ex_busy = eb; mem_busy = mb; irq = ir; ex_pc = pc;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic do_rst();
    @(posedge clk);
    #1;
    rst = 1'b1; jump_req = 1'b0; jump_addr = 32'h0; ld_use = 1'b0;
    ex_busy = 1'b0; mem_busy = 1'b0; irq = 1'b0; ex_pc = 32'h0;
  endtask

  // Monitor: outputs are combinational, checked mid-cycle against the queue.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {irq_ack_w, epc_w, state, jen, jaddr,
            pc_hold, if_id_hold, id_ex_hold, ex_mem_hold,
            if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, stall_err};
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL %s: got %h expected %h", nm, a, e);
      end
    end
  end

  localparam logic [1:0] RUN = 2'd0, RED = 2'd1, TRP = 2'd2, STL = 2'd3;

  initial begin
    repeat (2) @(posedge clk);
    vec("reset_idle", 0, 0, 0, 0, 0, 0, 0, ex(RUN, 0, 0, 4'b0000, 4'b0000, 0, 0, 0));

    vec("jump_c0", 1, 32'h80, 0, 0, 0, 0, 0, ex(RUN, 1, 32'h80, 4'b0000, 4'b1100, 0, 0, 0));
    vec("jump_c1", 0, 0, 0, 0, 0, 0, 0, ex(RED, 0, 0, 4'b0000, 4'b1000, 0, 0, 0));
    vec("jump_c2", 0, 0, 0, 0, 0, 0, 0, ex(RUN, 0, 0, 4'b0000, 4'b0000, 0, 0, 0));

    vec("exb_c1", 1, 32'h200, 0, 1, 0, 0, 0, ex(RUN, 0, 0, 4'b1110, 4'b0010, 0, 0, 0));
    vec("exb_c2", 1, 32'h200, 0, 1, 0, 0, 0, ex(STL, 0, 0, 4'b1110, 4'b0010, 0, 0, 0));
    vec("exb_c3", 1, 32'h200, 0, 1, 0, 0, 0, ex(STL, 0, 0, 4'b1110, 4'b0010, 0, 0, 0));
    vec("exb_jump", 1, 32'h200, 0, 0, 0, 0, 0, ex(STL, 1, 32'h200, 4'b0000, 4'b1100, 0, 0, 0));
    vec("exb_redir", 0, 0, 0, 0, 0, 0, 0, ex(RED, 0, 0, 4'b0000, 4'b1000, 0, 0, 0));
    vec("exb_run", 0, 0, 0, 0, 0, 0, 0, ex(RUN, 0, 0, 4'b0000, 4'b0000, 0, 0, 0));

    vec("memb_lduse", 0, 0, 1, 0, 1, 0, 0, ex(RUN, 0, 0, 4'b1111, 4'b0001, 0, 0, 0));
    vec("stall_exit", 0, 0, 0, 0, 0, 0, 0, ex(STL, 0, 0, 4'b0000, 4'b0000, 0, 0, 0));
    vec("lduse", 0, 0, 1, 0, 0, 0, 0, ex(RUN, 0, 0, 4'b1100, 4'b0100, 0, 0, 0));
    vec("lduse_keep_run", 0, 0, 0, 0, 0, 0, 0, ex(RUN, 0, 0, 4'b0000, 4'b0000, 0, 0, 0));

    vec("jump_b", 1, 32'h44, 0, 0, 0, 0, 0, ex(RUN, 1, 32'h44, 4'b0000, 4'b1100, 0, 0, 0));
    vec("redir_lduse", 0, 0, 1, 0, 0, 0, 0, ex(RED, 0, 0, 4'b1000, 4'b1100, 0, 0, 0));
    vec("after_redir", 0, 0, 0, 0, 0, 0, 0, ex(RUN, 0, 0, 4'b0000, 4'b0000, 0, 0, 0));

    vec("jump_over_ld", 1, 32'h3c, 1, 0, 0, 0, 0, ex(RUN, 1, 32'h3c, 4'b0000, 4'b1100, 0, 0, 0));
    vec("jol_redir", 0, 0, 0, 0, 0, 0, 0, ex(RED, 0, 0, 4'b0000, 4'b1000, 0, 0, 0));
    vec("both_busy", 1, 32'h10, 0, 1, 1, 0, 0, ex(RUN, 0, 0, 4'b1111, 4'b0001, 0, 0, 0));
    vec("both_exit", 0, 0, 0, 0, 0, 0, 0, ex(STL, 0, 0, 4'b0000, 4'b0000, 0, 0, 0));

    vec("err_c1", 0, 0, 0, 0, 1, 0, 0, ex(RUN, 0, 0, 4'b1111, 4'b0001, 0, 0, 0));
    vec("err_c2", 0, 0, 0, 0, 1, 0, 0, ex(STL, 0, 0, 4'b1111, 4'b0001, 0, 0, 0));
    vec("err_c3", 0, 0, 0, 0, 1, 0, 0, ex(STL, 0, 0, 4'b1111, 4'b0001, 0, 0, 0));
    vec("err_c4", 0, 0, 0, 0, 1, 0, 0, ex(STL, 0, 0, 4'b1111, 4'b0001, 0, 0, 0));
    vec("err_c5", 0, 0, 0, 0, 1, 0, 0, ex(STL, 0, 0, 4'b1111, 4'b0001, 1, 0, 0));
    vec("err_c6", 0, 0, 0, 0, 1, 0, 0, ex(STL, 0, 0, 4'b1111, 4'b0001, 1, 0, 0));
    vec("err_exit", 0, 0, 0, 0, 0, 0, 0, ex(STL, 0, 0, 4'b0000, 4'b0000, 1, 0, 0));
    vec("err_sticky", 0, 0, 0, 0, 0, 0, 0, ex(RUN, 0, 0, 4'b0000, 4'b0000, 1, 0, 0));
    do_rst();
    vec("err_cleared", 0, 0, 0, 0, 0, 0, 0, ex(RUN, 0, 0, 4'b0000, 4'b0000, 0, 0, 0));

    vec("pre_rst_jump", 1, 32'h80, 0, 0, 0, 0, 0, ex(RUN, 1, 32'h80, 4'b0000, 4'b1100, 0, 0, 0));
    do_rst();
    vec("rst_mid_redir", 0, 0, 0, 0, 0, 0, 0, ex(RUN, 0, 0, 4'b0000, 4'b0000, 0, 0, 0));
    vec("pre_rst_stall", 0, 0, 0, 0, 1, 0, 0, ex(RUN, 0, 0, 4'b1111, 4'b0001, 0, 0, 0));
    do_rst();
    vec("rst_mid_stall", 0, 0, 0, 0, 0, 0, 0, ex(RUN, 0, 0, 4'b0000, 4'b0000, 0, 0, 0));

`ifdef PIPE_CTRL_IRQ_EN
    vec("irq_entry", 0, 0, 0, 0, 0, 1, 32'h40, ex(RUN, 1, 32'h100, 4'b0000, 4'b1110, 0, 0, 32'h0));
    vec("irq_trap", 0, 0, 0, 0, 0, 1, 32'h44, ex(TRP, 0, 0, 4'b0000, 4'b1000, 0, 1, 32'h40));
    vec("irq_ret_run", 0, 0, 0, 0, 0, 0, 0, ex(RUN, 0, 0, 4'b0000, 4'b0000, 0, 0, 32'h40));
    vec("irq_busy", 0, 0, 0, 1, 0, 1, 32'h48, ex(RUN, 0, 0, 4'b1110, 4'b0010, 0, 0, 32'h40));
    vec("irq_in_stall", 0, 0, 0, 0, 0, 1, 32'h48, ex(STL, 1, 32'h100, 4'b0000, 4'b1110, 0, 0, 32'h40));
    vec("irq_trap2", 0, 0, 0, 0, 0, 0, 0, ex(TRP, 0, 0, 4'b0000, 4'b1000, 0, 1, 32'h48));
    vec("irq_jump", 1, 32'h80, 0, 0, 0, 0, 0, ex(RUN, 1, 32'h80, 4'b0000, 4'b1100, 0, 0, 32'h48));
    vec("irq_in_redir", 0, 0, 0, 0, 0, 1, 32'h50, ex(RED, 0, 0, 4'b0000, 4'b1000, 0, 0, 32'h48));
    vec("irq_after", 0, 0, 0, 0, 0, 0, 0, ex(RUN, 0, 0, 4'b0000, 4'b0000, 0, 0, 32'h48));
`endif

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
